// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, picks the next PC from the sequential,
// branch, jump and exception sources, runs the instruction-memory request /
// ready handshake and presents fetched instructions to the IF/ID boundary.
// A one-entry skid buffer holds a word that returns while the pipeline is
// stalled, so no fetched instruction is ever lost or duplicated.
//
// Handshake: imem_req is high only in FETCH, with imem_addr = pc. A response
// counts only in a cycle where imem_req and imem_ready are both high and no
// redirect is present; the pc advances only once the word has been handed
// to IF/ID (directly, or later from the skid buffer).
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] pc,
    output logic        misalign,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_misalign;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    logic [31:0] w_pc_nxt;
    logic        w_if_valid_nxt;
    logic [31:0] w_if_instr_nxt;
    logic [31:0] w_if_pc_nxt;
    logic        w_misalign_nxt;
    logic [31:0] w_skid_instr_nxt;
    logic [31:0] w_skid_pc_nxt;

    logic        w_redirect;
    logic        w_misaligned;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_req;

    // Redirect arbitration: exc beats jump beats branch; an unaligned jump or
    // branch target is diverted to the exception vector.
    always_comb begin
        w_redirect   = exc | jump | branch_taken;
        w_misaligned = 1'b0;
        w_target     = EXC_VECTOR;
        if (exc) begin
            w_target = EXC_VECTOR;
        end else if (jump) begin
            w_misaligned = (jump_target[1:0] != 2'b00);
            w_target     = w_misaligned ? EXC_VECTOR : jump_target;
        end else if (branch_taken) begin
            w_misaligned = (branch_target[1:0] != 2'b00);
            w_target     = w_misaligned ? EXC_VECTOR : branch_target;
        end
    end

    assign w_pc_plus4 = r_pc + 32'd4;

    // Next-state and next-datapath selection; every value holds by default.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_if_valid_nxt   = r_if_valid;
        w_if_instr_nxt   = r_if_instr;
        w_if_pc_nxt      = r_if_pc;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;
        w_misalign_nxt   = w_redirect & w_misaligned;
        w_req            = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                end
            end

            ST_FETCH: begin
                w_req = 1'b1;
                if (w_redirect) begin
                    // Any same-cycle response belongs to the abandoned path.
                    w_pc_nxt       = w_target;
                    w_if_valid_nxt = 1'b0;
                end else if (imem_ready && !stall) begin
                    w_if_instr_nxt = imem_rdata;
                    w_if_pc_nxt    = r_pc;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = w_pc_plus4;
                end else if (imem_ready && stall) begin
                    // Park the word; pc advances only when it is handed over.
                    w_skid_instr_nxt = imem_rdata;
                    w_skid_pc_nxt    = r_pc;
                    w_state_nxt      = ST_HELD;
                end else if (!stall) begin
                    w_if_valid_nxt = 1'b0;
                end
            end

            ST_HELD: begin
                if (w_redirect) begin
                    w_pc_nxt       = w_target;
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = ST_FETCH;
                end else if (!stall) begin
                    w_if_instr_nxt = r_skid_instr;
                    w_if_pc_nxt    = r_skid_pc;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = w_pc_plus4;
                    w_state_nxt    = ST_FETCH;
                end
            end

            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, IF/ID outputs, skid buffer and misalign pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_VECTOR;
            r_if_valid   <= 1'b0;
            r_if_instr   <= 32'h0000_0000;
            r_if_pc      <= 32'h0000_0000;
            r_misalign   <= 1'b0;
            r_skid_instr <= 32'h0000_0000;
            r_skid_pc    <= 32'h0000_0000;
        end else begin
            r_pc         <= w_pc_nxt;
            r_if_valid   <= w_if_valid_nxt;
            r_if_instr   <= w_if_instr_nxt;
            r_if_pc      <= w_if_pc_nxt;
            r_misalign   <= w_misalign_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc4      = r_if_pc + 32'd4;
    assign misalign    = r_misalign;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'h0000_0080;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] pc;
    logic        misalign;
    logic [1:0]  o_dbg_state;

    fetch_sequencer #(
        .RESET_VECTOR(RESET_VECTOR),
        .EXC_VECTOR  (EXC_VECTOR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exc          (exc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc4       (if_pc4),
        .pc           (pc),
        .misalign     (misalign),
        .o_dbg_state  (o_dbg_state)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // ---------------- reference model ----------------
    // exp_q holds {instr, pc} words already returned by memory but not yet
    // handed to IF/ID (at most one).
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ifpc;
    logic        m_mis;
    logic        m_booting;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic model_reset();
        exp_q.delete();
        m_pc      = RESET_VECTOR;
        m_valid   = 1'b0;
        m_instr   = 32'h0;
        m_ifpc    = 32'h0;
        m_mis     = 1'b0;
        m_booting = 1'b1;
    endtask

    task automatic model_clock(input logic s, input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt, input logic e,
                               input logic r);
        logic        redir;
        logic        bad_tgt;
        logic [31:0] tgt;
        logic [63:0] w;
        redir   = e | j | b;
        bad_tgt = !e && (j ? (jt[1:0] != 2'b00) : (b && bt[1:0] != 2'b00));
        if (e || bad_tgt) tgt = EXC_VECTOR;
        else if (j)       tgt = jt;
        else              tgt = bt;

        if (m_booting) begin
            m_booting = 1'b0;
            if (redir) m_pc = tgt;
        end else if (redir) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_pc    = tgt;
        end else if (exp_q.size() != 0) begin
            if (!s) begin
                w       = exp_q.pop_front();
                m_instr = w[63:32];
                m_ifpc  = w[31:0];
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end else if (r) begin
            if (!s) begin
                m_instr = mem_word(m_pc);
                m_ifpc  = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end else begin
                exp_q.push_back({mem_word(m_pc), m_pc});
            end
        end else if (!s) begin
            m_valid = 1'b0;
        end
        m_mis = redir && bad_tgt;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s@%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_req;
        exp_req = !m_booting && (exp_q.size() == 0);
        chk({tag, ".pc"},       pc,                 m_pc);
        chk({tag, ".addr"},     imem_addr,          m_pc);
        chk({tag, ".req"},      {31'b0, imem_req},  {31'b0, exp_req});
        chk({tag, ".valid"},    {31'b0, if_valid},  {31'b0, m_valid});
        chk({tag, ".instr"},    if_instr,           m_instr);
        chk({tag, ".if_pc"},    if_pc,              m_ifpc);
        chk({tag, ".if_pc4"},   if_pc4,             m_ifpc + 32'd4);
        chk({tag, ".misalign"}, {31'b0, misalign},  {31'b0, m_mis});
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input logic s, input logic r,
                        input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic e);
        stall         = s;
        imem_ready    = r;
        branch_taken  = b;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        exc           = e;
        @(posedge clk);
        cyc++;
        model_clock(s, b, bt, j, jt, e, r);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        check_all({tag, "_hold"});
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        stall = 1'b0; imem_ready = 1'b0; exc = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0;
        #2;
        do_reset("reset");

        // Free-running fetch: boot, then 0, 4 fetched.
        step("boot",  0, 1, 0, 0, 0, 0, 0);
        step("seq0",  0, 1, 0, 0, 0, 0, 0);
        step("seq4",  0, 1, 0, 0, 0, 0, 0);
        chk("pc_at_8", pc, 32'h8);
        // Memory not ready for three cycles at pc=8.
        for (int i = 0; i < 3; i++) step("wait8", 0, 0, 0, 0, 0, 0, 0);
        step("seq8",  0, 1, 0, 0, 0, 0, 0);
        chk("if_pc_8", if_pc, 32'h8);
        step("seqC",  0, 1, 0, 0, 0, 0, 0);
        // Stall with a returning word at 0x10: skid, hold, release.
        step("stall1", 1, 1, 0, 0, 0, 0, 0);
        step("stall2", 1, 1, 0, 0, 0, 0, 0);
        step("unstall", 0, 1, 0, 0, 0, 0, 0);
        chk("skid_if_pc", if_pc, 32'h10);
        chk("skid_pc",    pc,    32'h14);
        step("seq14", 0, 1, 0, 0, 0, 0, 0);
        // Branch and jump together under stall: jump wins, bubble inserted.
        step("br_jmp", 1, 1, 1, 32'h40, 1, 32'h80, 0);
        chk("br_jmp_pc", pc, 32'h80);
        step("seq80", 0, 1, 0, 0, 0, 0, 0);
        // Misaligned jump goes to the exception vector with a misalign pulse.
        step("jmp_mis", 0, 1, 0, 0, 1, 32'h102, 0);
        step("mis_drop", 0, 1, 0, 0, 0, 0, 0);
        step("exc", 0, 1, 0, 0, 0, 0, 1);
        step("after_exc", 0, 1, 0, 0, 0, 0, 0);
        // Misaligned branch.
        step("br_mis", 0, 1, 1, 32'h0000_0203, 0, 0, 0);
        // PC wrap.
        step("jmp_top", 0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0);
        step("seqTop",  0, 1, 0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0);
        step("seq0b",   0, 1, 0, 0, 0, 0, 0);
        // Enter HELD, then reset asynchronously mid-cycle.
        step("held1", 1, 1, 0, 0, 0, 0, 0);
        step("held2", 1, 0, 0, 0, 0, 0, 0);
        do_reset("async_rst");
        step("boot2", 0, 1, 0, 0, 0, 0, 0);
        step("post_rst", 0, 1, 0, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic        s, r, b, j, e;
            logic [31:0] bt, jt;
            s  = ($urandom_range(0, 99) < 30);
            r  = ($urandom_range(0, 99) < 70);
            b  = ($urandom_range(0, 99) < 6);
            j  = ($urandom_range(0, 99) < 4);
            e  = ($urandom_range(0, 99) < 2);
            bt = $urandom();
            jt = $urandom();
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
            step("rand", s, r, b, bt, j, jt, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
